// File: rtl/id_ex_stage_if.sv
// Bundle between the decode stage and the ID/EX pipeline register: decoded
// instruction fields plus flush/hold inward, registered EX fields plus stall outward.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              id_valid;
    logic              branch_eq, branch_ne, memread, memwrite;
    logic              memtoreg, regdst, regwrite, alusrc;
    logic [1:0]        aluop;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic              flush, hold;

    logic              stall;
    logic              ex_valid;
    logic              ex_branch_eq, ex_branch_ne, ex_memread, ex_memwrite;
    logic              ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc;
    logic [1:0]        ex_aluop;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;

    modport master (
        output id_valid, branch_eq, branch_ne, memread, memwrite,
               memtoreg, regdst, regwrite, alusrc, aluop,
               id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4,
               flush, hold,
        input  stall, ex_valid, ex_branch_eq, ex_branch_ne, ex_memread, ex_memwrite,
               ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc, ex_aluop,
               ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4
    );

    modport slave (
        input  id_valid, branch_eq, branch_ne, memread, memwrite,
               memtoreg, regdst, regwrite, alusrc, aluop,
               id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4,
               flush, hold,
        output stall, ex_valid, ex_branch_eq, ex_branch_ne, ex_memread, ex_memwrite,
               ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc, ex_aluop,
               ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and hold.
// Optional IDEX_PERF_CNT_EN adds saturating 16-bit stall_cnt / flush_cnt outputs.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef IDEX_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic              branch_eq;
        logic              branch_ne;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              regdst;
        logic              regwrite;
        logic              alusrc;
        logic [1:0]        aluop;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
    } ex_slot_t;

    ex_slot_t ex_q;
    ex_slot_t id_slot;
    logic     uses_rt;
    logic     hazard;

    // An empty decode slot still carries its data, but its control must not act.
    always_comb begin
        id_slot           = '0;
        id_slot.valid     = bus.id_valid;
        id_slot.rs        = bus.id_rs;
        id_slot.rt        = bus.id_rt;
        id_slot.rd        = bus.id_rd;
        id_slot.rdata1    = bus.id_rdata1;
        id_slot.rdata2    = bus.id_rdata2;
        id_slot.imm       = bus.id_imm;
        id_slot.pc4       = bus.id_pc4;
        if (bus.id_valid) begin
            id_slot.branch_eq = bus.branch_eq;
            id_slot.branch_ne = bus.branch_ne;
            id_slot.memread   = bus.memread;
            id_slot.memwrite  = bus.memwrite;
            id_slot.memtoreg  = bus.memtoreg;
            id_slot.regdst    = bus.regdst;
            id_slot.regwrite  = bus.regwrite;
            id_slot.alusrc    = bus.alusrc;
            id_slot.aluop     = bus.aluop;
        end
    end

    // lw/addi take their second operand from the immediate; sw still reads rt as store data.
    assign uses_rt = bus.id_valid & (~bus.alusrc | bus.memwrite);
    assign hazard  = ex_q.valid & ex_q.memread & (ex_q.rt != '0) & bus.id_valid &
                     ((ex_q.rt == bus.id_rs) | (uses_rt & (ex_q.rt == bus.id_rt)));
    assign bus.stall = rst_n & (bus.hold | (~bus.flush & hazard));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.hold) begin
            ex_q <= ex_q;
        end else if (bus.flush || hazard) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_slot;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!bus.hold) begin
            if (bus.flush) begin
                if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
            end else if (hazard) begin
                if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_branch_eq = ex_q.branch_eq;
    assign bus.ex_branch_ne = ex_q.branch_ne;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_regdst    = ex_q.regdst;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_rdata1    = ex_q.rdata1;
    assign bus.ex_rdata2    = ex_q.rdata2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_pc4       = ex_q.pc4;

endmodule
